// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage and its PC counter, instruction memory and decode.
// master is the fetch unit side; slave is the surrounding environment.
interface fetch_unit_if;
    logic [31:0] pc_in;
    logic        pc_en;
    logic        redirect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fault;

    modport master (
        input  pc_in, redirect, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        output pc_en, imem_req, imem_addr, instr_valid, instr, instr_pc, fault
    );

    modport slave (
        output pc_in, redirect, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        input  pc_en, imem_req, imem_addr, instr_valid, instr, instr_pc, fault
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited word fetches, in-order response buffering, redirect flush.
// Optional misaligned-fetch trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_L  = SUM_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [31:0]      fifo_instr_r [DEPTH];
    logic [31:0]      fifo_pc_r    [DEPTH];
    logic [PTR_W-1:0] fifo_wr_ptr_r;
    logic [PTR_W-1:0] fifo_rd_ptr_r;
    logic [CNT_W-1:0] fifo_cnt_r;

    logic [31:0]      pend_pc_r    [DEPTH];
    logic [PTR_W-1:0] pend_wr_ptr_r;
    logic [PTR_W-1:0] pend_rd_ptr_r;
    logic [CNT_W-1:0] out_cnt_r;
    logic [CNT_W-1:0] discard_cnt_r;

    logic [SUM_W-1:0] credit_sum_s;
    logic             credit_ok_s;
    logic             halt_s;
    logic             req_s;
    logic             issue_s;
    logic             resp_s;
    logic             drop_s;
    logic             push_s;
    logic             valid_s;
    logic             pop_s;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_r;
    logic misalign_s;

    assign misalign_s = (bus.pc_in[1:0] != 2'b00);
    assign halt_s     = misalign_s || fault_r;
    assign bus.fault  = fault_r;

    // Sticky misalign trap, raised only when a fetch would otherwise have gone out.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_r <= 1'b0;
        end else if (bus.redirect) begin
            fault_r <= 1'b0;
        end else if (credit_ok_s && misalign_s) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end
`else
    assign halt_s    = 1'b0;
    assign bus.fault = 1'b0;
`endif

    // Issue/response/decode handshake decode; each outstanding fetch owns a future FIFO slot.
    always_comb begin
        credit_sum_s = SUM_W'(out_cnt_r) + SUM_W'(fifo_cnt_r);
        credit_ok_s  = (credit_sum_s < DEPTH_L);
        req_s        = !reset && !bus.redirect && credit_ok_s && !halt_s;
        issue_s      = req_s && bus.imem_gnt;
        resp_s       = bus.imem_rvalid && (out_cnt_r != CNT_ZERO);
        drop_s       = resp_s && (bus.redirect || (discard_cnt_r != CNT_ZERO));
        push_s       = resp_s && !drop_s;
        valid_s      = !reset && (fifo_cnt_r != CNT_ZERO);
        pop_s        = valid_s && bus.instr_ready && !bus.redirect;
    end

    assign bus.imem_req    = req_s;
    assign bus.imem_addr   = {bus.pc_in[31:2], 2'b00};
    assign bus.pc_en       = !reset && (issue_s || bus.redirect);
    assign bus.instr_valid = valid_s;
    assign bus.instr       = fifo_instr_r[fifo_rd_ptr_r];
    assign bus.instr_pc    = fifo_pc_r[fifo_rd_ptr_r];

    // Pointer and counter state; a redirect flushes the buffer and marks every in-flight fetch stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_wr_ptr_r <= PTR_ZERO;
            pend_rd_ptr_r <= PTR_ZERO;
            out_cnt_r     <= CNT_ZERO;
            discard_cnt_r <= CNT_ZERO;
            fifo_wr_ptr_r <= PTR_ZERO;
            fifo_rd_ptr_r <= PTR_ZERO;
            fifo_cnt_r    <= CNT_ZERO;
        end else begin
            if (issue_s) begin
                pend_wr_ptr_r <= pend_wr_ptr_r + PTR_ONE;
            end
            if (resp_s) begin
                pend_rd_ptr_r <= pend_rd_ptr_r + PTR_ONE;
            end
            out_cnt_r <= out_cnt_r + CNT_W'(issue_s) - CNT_W'(resp_s);

            if (bus.redirect) begin
                discard_cnt_r <= out_cnt_r - CNT_W'(resp_s);
            end else if (resp_s && (discard_cnt_r != CNT_ZERO)) begin
                discard_cnt_r <= discard_cnt_r - CNT_ONE;
            end

            if (bus.redirect) begin
                fifo_wr_ptr_r <= PTR_ZERO;
                fifo_rd_ptr_r <= PTR_ZERO;
                fifo_cnt_r    <= CNT_ZERO;
            end else begin
                if (push_s) begin
                    fifo_wr_ptr_r <= fifo_wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    fifo_rd_ptr_r <= fifo_rd_ptr_r + PTR_ONE;
                end
                fifo_cnt_r <= fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
            end
        end
    end

    // Storage arrays need no reset: the pointers and counts define which entries are live.
    always_ff @(posedge clk) begin
        if (issue_s) begin
            pend_pc_r[pend_wr_ptr_r] <= bus.pc_in;
        end
        if (push_s) begin
            fifo_instr_r[fifo_wr_ptr_r] <= bus.imem_rdata;
            fifo_pc_r[fifo_wr_ptr_r]    <= pend_pc_r[pend_rd_ptr_r];
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit; the bench plays PC counter, instruction memory and decode,
// and predicts outputs from a queue-level model of in-flight fetches and buffered instructions.
module tb_fetch_unit;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct { logic [31:0] pc; bit stale; int due; } fetch_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } entry_t;

    fetch_t      inflight_q[$];
    entry_t      instq[$];
    logic [31:0] pc_m;
    bit          fault_m;
    int          cyc;

    bit          rst_k, redir_k, stray_k;
    logic [31:0] tgt_k;
    int          gnt_pct, rv_pct, ready_pct, lat_min, lat_max;

    bit          gnt_d, rv_d, rdy_d;
    bit          exp_req, exp_pc_en, exp_valid, exp_fault;
    logic [31:0] exp_addr, exp_instr, exp_ipc;
    logic        obs_req, obs_pc_en, obs_valid, obs_fault;
    logic [31:0] obs_addr, obs_instr, obs_ipc;

    int n_checks;
    int n_pass;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
    endfunction

    // One clock cycle: drive inputs, predict, sample after settling, then advance the model.
    task automatic tick();
        bit          misal, credit, issue;
        fetch_t      f;
        logic [31:0] waddr;
        int          lat;
        @(negedge clk);
        reset = rst_k;
        gnt_d = (int'($urandom_range(99)) < gnt_pct);
        rdy_d = (int'($urandom_range(99)) < ready_pct);
        rv_d  = stray_k;
        waddr = 32'hDEAD_BEEF;
        if (inflight_q.size() > 0) begin
            waddr = {inflight_q[0].pc[31:2], 2'b00};
            if (inflight_q[0].due <= cyc && int'($urandom_range(99)) < rv_pct) rv_d = 1'b1;
        end
        bus.pc_in       = pc_m;
        bus.redirect    = redir_k;
        bus.imem_gnt    = gnt_d;
        bus.imem_rvalid = rv_d;
        bus.imem_rdata  = (inflight_q.size() > 0) ? mem_word(waddr) : waddr;
        bus.instr_ready = rdy_d;

        credit = (inflight_q.size() + instq.size()) < DEPTH;
`ifdef FETCH_MISALIGN_TRAP_EN
        misal = (pc_m[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        exp_req   = !rst_k && !redir_k && credit && !misal && !fault_m;
        exp_addr  = {pc_m[31:2], 2'b00};
        issue     = exp_req && gnt_d;
        exp_pc_en = !rst_k && (issue || redir_k);
        exp_valid = !rst_k && (instq.size() > 0);
        exp_instr = (instq.size() > 0) ? instq[0].instr : 32'h0;
        exp_ipc   = (instq.size() > 0) ? instq[0].pc : 32'h0;
        exp_fault = fault_m;

        #1;
        obs_req   = bus.imem_req;
        obs_addr  = bus.imem_addr;
        obs_pc_en = bus.pc_en;
        obs_valid = bus.instr_valid;
        obs_instr = bus.instr;
        obs_ipc   = bus.instr_pc;
        obs_fault = bus.fault;

        @(posedge clk);
        if (rst_k) begin
            inflight_q.delete();
            instq.delete();
            pc_m    = RESET_PC;
            fault_m = 1'b0;
        end else begin
            if (redir_k) begin
                instq.delete();
                foreach (inflight_q[i]) inflight_q[i].stale = 1'b1;
            end else if (exp_valid && rdy_d) begin
                void'(instq.pop_front());
            end
            if (rv_d && inflight_q.size() > 0) begin
                f = inflight_q.pop_front();
                if (!f.stale) instq.push_back('{instr: mem_word({f.pc[31:2], 2'b00}), pc: f.pc});
            end
            if (issue) begin
                lat = int'($urandom_range(lat_max, lat_min));
                inflight_q.push_back('{pc: pc_m, stale: 1'b0, due: cyc + lat});
            end
            if (redir_k) fault_m = 1'b0;
            else if (credit && misal) fault_m = 1'b1;
            if (redir_k) pc_m = tgt_k;
            else if (issue) pc_m = pc_m + 32'd4;
        end
        cyc++;
    endtask

    task automatic set_knobs(input int g, input int rv, input int rdy, input int lmin, input int lmax);
        gnt_pct = g; rv_pct = rv; ready_pct = rdy; lat_min = lmin; lat_max = lmax;
        redir_k = 1'b0; stray_k = 1'b0; rst_k = 1'b0;
    endtask

    task automatic test_reset();
        set_knobs(100, 100, 100, 1, 1);
        rst_k = 1'b1;
        repeat (3) begin
            tick();
            n_checks++;
            if (obs_req !== 1'b0 || obs_pc_en !== 1'b0 || obs_valid !== 1'b0 || obs_fault !== 1'b0)
                $display("FAIL reset_outputs: req=%b pc_en=%b valid=%b fault=%b, required 0000", obs_req, obs_pc_en, obs_valid, obs_fault);
            else n_pass++;
        end
        rst_k = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] want;
        set_knobs(100, 100, 100, 1, 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if (obs_pc_en !== 1'b1 || obs_addr !== 32'(4 * k))
                $display("FAIL stream_issue k=%0d: pc_en=%b addr=%h, required 1 %h", k, obs_pc_en, obs_addr, 32'(4 * k));
            else n_pass++;
            want = 32'(4 * (k - 2));
            n_checks++;
            if (k < 2 && obs_valid !== 1'b0)
                $display("FAIL stream_latency k=%0d: valid=%b, required 0", k, obs_valid);
            else if (k >= 2 && (obs_valid !== 1'b1 || obs_ipc !== want || obs_instr !== mem_word(want)))
                $display("FAIL stream_instr k=%0d: valid=%b pc=%h instr=%h, required 1 %h %h", k, obs_valid, obs_ipc, obs_instr, want, mem_word(want));
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int          issues;
        int          seen;
        bit          got_issue;
        logic [31:0] first_addr;
        set_knobs(100, 100, 0, 1, 1);
        rst_k = 1'b1; tick(); rst_k = 1'b0;
        issues = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (obs_pc_en === 1'b1) issues++;
        end
        n_checks++;
        if (issues !== 4) $display("FAIL bp_issue_count: %0d issues, required 4", issues);
        else n_pass++;
        n_checks++;
        if (obs_req !== 1'b0 || obs_pc_en !== 1'b0 || obs_valid !== 1'b1)
            $display("FAIL bp_stalled: req=%b pc_en=%b valid=%b, required 0 0 1", obs_req, obs_pc_en, obs_valid);
        else n_pass++;
        ready_pct = 100;
        seen = 0; got_issue = 1'b0; first_addr = 32'h0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!got_issue && obs_pc_en === 1'b1) begin got_issue = 1'b1; first_addr = obs_addr; end
            if (obs_valid === 1'b1 && seen < 4) begin
                n_checks++;
                if (obs_ipc !== 32'(4 * seen) || obs_instr !== mem_word(32'(4 * seen)))
                    $display("FAIL bp_drain_order #%0d: pc=%h instr=%h, required %h %h", seen, obs_ipc, obs_instr, 32'(4 * seen), mem_word(32'(4 * seen)));
                else n_pass++;
                seen++;
            end
        end
        n_checks++;
        if (seen !== 4 || first_addr !== 32'h10)
            $display("FAIL bp_resume: drained %0d resume_addr=%h, required 4 00000010", seen, first_addr);
        else n_pass++;
    endtask

    task automatic test_grant_stall();
        set_knobs(100, 100, 100, 1, 1);
        rst_k = 1'b1; tick(); rst_k = 1'b0;
        redir_k = 1'b1; tgt_k = 32'h20; tick(); redir_k = 1'b0;
        gnt_pct = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (obs_req !== 1'b1 || obs_addr !== 32'h20 || obs_pc_en !== 1'b0)
                $display("FAIL stall_hold k=%0d: req=%b addr=%h pc_en=%b, required 1 00000020 0", k, obs_req, obs_addr, obs_pc_en);
            else n_pass++;
        end
        gnt_pct = 100; tick();
        n_checks++;
        if (obs_pc_en !== 1'b1 || obs_addr !== 32'h20)
            $display("FAIL stall_grant: pc_en=%b addr=%h, required 1 00000020", obs_pc_en, obs_addr);
        else n_pass++;
        gnt_pct = 0; tick();
        n_checks++;
        if (obs_pc_en !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h24)
            $display("FAIL stall_single_pulse: pc_en=%b req=%b addr=%h, required 0 1 00000024", obs_pc_en, obs_req, obs_addr);
        else n_pass++;
    endtask

    task automatic test_redirect();
        bit got;
        set_knobs(100, 100, 100, 3, 3);
        rst_k = 1'b1; tick(); rst_k = 1'b0;
        redir_k = 1'b1; tgt_k = 32'h40; tick(); redir_k = 1'b0;
        tick(); tick();
        redir_k = 1'b1; tgt_k = 32'h100; tick(); redir_k = 1'b0;
        n_checks++;
        if (obs_pc_en !== 1'b1 || obs_req !== 1'b0)
            $display("FAIL redirect_cycle: pc_en=%b req=%b, required 1 0", obs_pc_en, obs_req);
        else n_pass++;
        tick();
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h100 || obs_valid !== 1'b0)
            $display("FAIL redirect_target: req=%b addr=%h valid=%b, required 1 00000100 0", obs_req, obs_addr, obs_valid);
        else n_pass++;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            tick();
            if (obs_valid === 1'b1) begin
                got = 1'b1;
                n_checks++;
                if (obs_ipc !== 32'h100 || obs_instr !== mem_word(32'h100))
                    $display("FAIL redirect_first_instr: pc=%h instr=%h, required 00000100 %h", obs_ipc, obs_instr, mem_word(32'h100));
                else n_pass++;
            end
        end
        if (!got) begin n_checks++; $display("FAIL redirect_timeout: no instr_valid within 12 cycles, required one"); end
    endtask

    task automatic test_reset_mid();
        bit got;
        set_knobs(100, 100, 0, 1, 1);
        rst_k = 1'b1; tick(); rst_k = 1'b0;
        repeat (4) tick();
        rv_pct = 0; rst_k = 1'b1; tick(); rst_k = 1'b0;
        rv_pct = 100; ready_pct = 100; stray_k = 1'b1; tick(); stray_k = 1'b0;
        n_checks++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== RESET_PC)
            $display("FAIL reset_mid_restart: valid=%b req=%b addr=%h, required 0 1 %h", obs_valid, obs_req, obs_addr, RESET_PC);
        else n_pass++;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            tick();
            if (obs_valid === 1'b1) begin
                got = 1'b1;
                n_checks++;
                if (obs_ipc !== RESET_PC || obs_instr !== mem_word(RESET_PC))
                    $display("FAIL reset_mid_first_instr: pc=%h instr=%h, required %h %h", obs_ipc, obs_instr, RESET_PC, mem_word(RESET_PC));
                else n_pass++;
            end
        end
        if (!got) begin n_checks++; $display("FAIL reset_mid_timeout: no instr_valid within 8 cycles, required one"); end
    endtask

`ifdef FETCH_MISALIGN_TRAP_EN
    task automatic test_misalign();
        set_knobs(100, 100, 100, 1, 1);
        rst_k = 1'b1; tick(); rst_k = 1'b0;
        redir_k = 1'b1; tgt_k = 32'h102; tick(); redir_k = 1'b0;
        tick();
        n_checks++;
        if (obs_req !== 1'b0 || obs_pc_en !== 1'b0 || obs_fault !== 1'b0)
            $display("FAIL misalign_block: req=%b pc_en=%b fault=%b, required 0 0 0", obs_req, obs_pc_en, obs_fault);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (obs_fault !== 1'b1 || obs_req !== 1'b0 || obs_pc_en !== 1'b0)
                $display("FAIL misalign_sticky k=%0d: fault=%b req=%b pc_en=%b, required 1 0 0", k, obs_fault, obs_req, obs_pc_en);
            else n_pass++;
        end
        redir_k = 1'b1; tgt_k = 32'h200; tick(); redir_k = 1'b0;
        n_checks++;
        if (obs_pc_en !== 1'b1) $display("FAIL misalign_redirect: pc_en=%b, required 1", obs_pc_en);
        else n_pass++;
        tick();
        n_checks++;
        if (obs_fault !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h200)
            $display("FAIL misalign_clear: fault=%b req=%b addr=%h, required 0 1 00000200", obs_fault, obs_req, obs_addr);
        else n_pass++;
    endtask
`else
    task automatic test_misalign();
        bit got;
        set_knobs(100, 100, 100, 1, 1);
        rst_k = 1'b1; tick(); rst_k = 1'b0;
        redir_k = 1'b1; tgt_k = 32'h102; tick(); redir_k = 1'b0;
        tick();
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h100 || obs_fault !== 1'b0)
            $display("FAIL misalign_ignored: req=%b addr=%h fault=%b, required 1 00000100 0", obs_req, obs_addr, obs_fault);
        else n_pass++;
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            tick();
            if (obs_valid === 1'b1) begin
                got = 1'b1;
                n_checks++;
                if (obs_ipc !== 32'h102 || obs_instr !== mem_word(32'h100))
                    $display("FAIL misalign_instr: pc=%h instr=%h, required 00000102 %h", obs_ipc, obs_instr, mem_word(32'h100));
                else n_pass++;
            end
        end
        if (!got) begin n_checks++; $display("FAIL misalign_timeout: no instr_valid within 6 cycles, required one"); end
    endtask
`endif

    task automatic test_random();
        set_knobs(70, 70, 60, 1, 4);
        rst_k = 1'b1; tick(); rst_k = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            rst_k   = (int'($urandom_range(199)) == 0);
            redir_k = (int'($urandom_range(99)) < 5);
            tgt_k   = $urandom() & 32'hFFFF_FFFC;
            tick();
            n_checks++;
            if (obs_req !== exp_req || obs_pc_en !== exp_pc_en || obs_valid !== exp_valid || obs_fault !== exp_fault)
                $display("FAIL random_ctrl cyc=%0d: req,pc_en,valid,fault=%b%b%b%b, required %b%b%b%b",
                         cyc, obs_req, obs_pc_en, obs_valid, obs_fault, exp_req, exp_pc_en, exp_valid, exp_fault);
            else n_pass++;
            if (exp_req) begin
                n_checks++;
                if (obs_addr !== exp_addr) $display("FAIL random_addr cyc=%0d: addr=%h, required %h", cyc, obs_addr, exp_addr);
                else n_pass++;
            end
            if (exp_valid) begin
                n_checks++;
                if (obs_instr !== exp_instr || obs_ipc !== exp_ipc)
                    $display("FAIL random_head cyc=%0d: instr=%h pc=%h, required %h %h", cyc, obs_instr, obs_ipc, exp_instr, exp_ipc);
                else n_pass++;
            end
        end
        rst_k = 1'b0; redir_k = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.pc_in       = RESET_PC;
        bus.redirect    = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.instr_ready = 1'b0;
        pc_m = RESET_PC; fault_m = 1'b0; cyc = 0;
        tgt_k = 32'h0; n_checks = 0; n_pass = 0;
        set_knobs(100, 100, 100, 1, 1);
        test_reset();
        test_stream();
        test_backpressure();
        test_grant_stall();
        test_redirect();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
